hazard_unit_sb: RTL and testbench

Parametrised hazard unit for the 5-stage pipelined MIPS. It adds a scoreboard for one multi-cycle multiply/divide unit, source-use qualification to avoid false stalls, and a selectable forwarding mode (forward or stall-only). It also keeps a saturating stall-cycle counter. It sits beside the datapath and drives the F/D stall enables, the E flush, and the E- and D-stage forwarding muxes.

---
 rtl/hazard_unit_sb.sv | 180 ++++++++++++++++++
 tb/tb_hazard_unit_sb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_sb.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, load/branch/RAW stalls,
// a one-entry scoreboard for the multi-cycle multiply/divide unit, and a stall counter.
//
// state  | meaning
// S_IDLE | multiply/divide unit free
// S_BUSY | operation in flight; cnt_q counts down to the result-write cycle
module hazard_unit_sb #(
   parameter int REGBITS = 5,
   parameter int MD_LAT  = 4,
   parameter int FWD_EN  = 1,
   parameter int CNTW    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               BranchD,
   input  logic               JumpD,
   input  logic [REGBITS-1:0] RsD,
   input  logic [REGBITS-1:0] RtD,
   input  logic               UsesRsD,
   input  logic               UsesRtD,
   input  logic [REGBITS-1:0] WriteRegD,
   input  logic               RegWriteD,
   input  logic               MDStartD,
   input  logic [REGBITS-1:0] RsE,
   input  logic [REGBITS-1:0] RtE,
   input  logic [REGBITS-1:0] WriteRegE,
   input  logic               RegWriteE,
   input  logic               MemtoRegE,
   input  logic               MDIssueE,
   input  logic [REGBITS-1:0] WriteRegM,
   input  logic               RegWriteM,
   input  logic               MemtoRegM,
   input  logic [REGBITS-1:0] WriteRegW,
   input  logic               RegWriteW,
   input  logic               ClrCount,
   output logic               StallF,
   output logic               StallD,
   output logic               FlushE,
   output logic               ForwardAD,
   output logic               ForwardBD,
   output logic [1:0]         ForwardAE,
   output logic [1:0]         ForwardBE,
   output logic               MDBusy,
   output logic               MDDone,
   output logic [REGBITS-1:0] MDWriteReg,
   output logic [CNTW-1:0]    StallCount
);

   localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LAT - 1);
   localparam bit FWD = (FWD_EN != 0);

   typedef enum logic {S_IDLE, S_BUSY} md_state_e;

   md_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [REGBITS-1:0] md_reg_q, md_reg_d;
   logic [CNTW-1:0]    stall_cnt_q, stall_cnt_d;

   logic md_pending;
   logic lwstall, branchstall, rawstall, mdstall, stall;
   logic unused_jump;

   // Jumps resolve in D without reading registers, so they never stall.
   assign unused_jump = JumpD;

   function automatic logic match(input logic [REGBITS-1:0] x, input logic [REGBITS-1:0] y);
      return (x != '0) && (x == y);
   endfunction

   function automatic logic src_hit(input logic [REGBITS-1:0] rs, input logic urs,
                                    input logic [REGBITS-1:0] rt, input logic urt,
                                    input logic [REGBITS-1:0] r);
      return (urs && match(rs, r)) || (urt && match(rt, r));
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [REGBITS-1:0] src,
                                          input logic [REGBITS-1:0] wm, input logic rwm,
                                          input logic [REGBITS-1:0] ww, input logic rww);
      if (rwm && match(src, wm))      return 2'b10;
      else if (rww && match(src, ww)) return 2'b01;
      else                            return 2'b00;
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      md_reg_d = md_reg_q;
      case (state_q)
         S_IDLE: begin
            if (MDIssueE) begin
               state_d  = S_BUSY;
               cnt_d    = CNT_LOAD;
               md_reg_d = WriteRegE;
            end
         end
         S_BUSY: begin
            // An issue while the count is still running is ignored.
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (MDIssueE) begin
               cnt_d    = CNT_LOAD;
               md_reg_d = WriteRegE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         md_reg_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         md_reg_q <= md_reg_d;
      end
   end

   assign MDBusy     = (state_q == S_BUSY);
   assign md_pending = MDBusy && (cnt_q != '0);
   assign MDDone     = MDBusy && (cnt_q == '0) && !reset;
   assign MDWriteReg = md_reg_q;

   always_comb begin
      lwstall     = MemtoRegE && src_hit(RsD, UsesRsD, RtD, UsesRtD, RtE);
      branchstall = BranchD &&
                    ((RegWriteE && src_hit(RsD, UsesRsD, RtD, UsesRtD, WriteRegE)) ||
                     (MemtoRegM && src_hit(RsD, UsesRsD, RtD, UsesRtD, WriteRegM)));
      rawstall    = !FWD &&
                    ((RegWriteE && src_hit(RsD, UsesRsD, RtD, UsesRtD, WriteRegE)) ||
                     (RegWriteM && src_hit(RsD, UsesRsD, RtD, UsesRtD, WriteRegM)));
      // Result is written through during MDDone, so readers release in that cycle.
      mdstall     = (md_pending &&
                     (src_hit(RsD, UsesRsD, RtD, UsesRtD, md_reg_q) ||
                      (RegWriteD && match(WriteRegD, md_reg_q)))) ||
                    (MDIssueE &&
                     (src_hit(RsD, UsesRsD, RtD, UsesRtD, WriteRegE) ||
                      match(WriteRegD, WriteRegE))) ||
                    (MDStartD && (md_pending || MDIssueE));
      stall       = !reset && (lwstall || branchstall || rawstall || mdstall);
   end

   assign StallF = stall;
   assign StallD = stall;
   assign FlushE = stall || reset;

   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      if (FWD && !reset) begin
         ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
         ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
         ForwardAD = RegWriteM && match(RsD, WriteRegM);
         ForwardBD = RegWriteM && match(RtD, WriteRegM);
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (ClrCount)
         stall_cnt_d = '0;
      else if (stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Directed bench for hazard_unit_sb: a forwarding instance (MD_LAT=4) and a
// stall-only instance (MD_LAT=1, CNTW=2) driven by the same pipeline inputs.
module tb_hazard_unit_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, BranchD, JumpD, UsesRsD, UsesRtD, RegWriteD, MDStartD;
   logic [4:0] RsD, RtD, WriteRegD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, MemtoRegE, MDIssueE, RegWriteM, MemtoRegM, RegWriteW, ClrCount;

   logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, MDBusy, MDDone;
   logic [1:0] ForwardAE, ForwardBE;
   logic [4:0] MDWriteReg;
   logic [15:0] StallCount;

   logic       n_StallF, n_StallD, n_FlushE, n_ForwardAD, n_ForwardBD, n_MDBusy, n_MDDone;
   logic [1:0] n_ForwardAE, n_ForwardBE;
   logic [4:0] n_MDWriteReg;
   logic [1:0] n_StallCount;

   int n_tests = 0;
   int n_fail  = 0;

   hazard_unit_sb #(.REGBITS(5), .MD_LAT(4), .FWD_EN(1), .CNTW(16)) u_fwd (
      .clk(clk), .reset(reset), .BranchD(BranchD), .JumpD(JumpD), .RsD(RsD), .RtD(RtD),
      .UsesRsD(UsesRsD), .UsesRtD(UsesRtD), .WriteRegD(WriteRegD), .RegWriteD(RegWriteD),
      .MDStartD(MDStartD), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
      .MemtoRegE(MemtoRegE), .MDIssueE(MDIssueE), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
      .MemtoRegM(MemtoRegM), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .ClrCount(ClrCount),
      .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .ForwardAD(ForwardAD),
      .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MDBusy(MDBusy),
      .MDDone(MDDone), .MDWriteReg(MDWriteReg), .StallCount(StallCount));

   hazard_unit_sb #(.REGBITS(5), .MD_LAT(1), .FWD_EN(0), .CNTW(2)) u_nofwd (
      .clk(clk), .reset(reset), .BranchD(BranchD), .JumpD(JumpD), .RsD(RsD), .RtD(RtD),
      .UsesRsD(UsesRsD), .UsesRtD(UsesRtD), .WriteRegD(WriteRegD), .RegWriteD(RegWriteD),
      .MDStartD(MDStartD), .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
      .MemtoRegE(MemtoRegE), .MDIssueE(MDIssueE), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
      .MemtoRegM(MemtoRegM), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .ClrCount(ClrCount),
      .StallF(n_StallF), .StallD(n_StallD), .FlushE(n_FlushE), .ForwardAD(n_ForwardAD),
      .ForwardBD(n_ForwardBD), .ForwardAE(n_ForwardAE), .ForwardBE(n_ForwardBE),
      .MDBusy(n_MDBusy), .MDDone(n_MDDone), .MDWriteReg(n_MDWriteReg),
      .StallCount(n_StallCount));

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      BranchD = 0; JumpD = 0; RsD = 0; RtD = 0; UsesRsD = 0; UsesRtD = 0;
      WriteRegD = 0; RegWriteD = 0; MDStartD = 0; RsE = 0; RtE = 0; WriteRegE = 0;
      RegWriteE = 0; MemtoRegE = 0; MDIssueE = 0; WriteRegM = 0; RegWriteM = 0;
      MemtoRegM = 0; WriteRegW = 0; RegWriteW = 0; ClrCount = 0;
   endtask

   initial begin
      bit seen_done;
      clear_in();
      reset = 1;
      tick(); tick();
      RsE = 1; WriteRegM = 1; RegWriteM = 1; #1;
      chk("rst_flush", int'(FlushE), 1);
      chk("rst_stall", int'(StallD), 0);
      chk("rst_fwdae", int'(ForwardAE), 0);
      chk("rst_mddone", int'(MDDone), 0);
      chk("rst_busy", int'(MDBusy), 0);
      chk("rst_mdreg", int'(MDWriteReg), 0);
      chk("rst_cnt", int'(StallCount), 0);

      // E-stage forwarding priority M > W, register 0 never forwards
      reset = 0; #1;
      chk("fwd_ae_m", int'(ForwardAE), 2);
      chk("nofwd_ae", int'(n_ForwardAE), 0);
      RegWriteM = 0; WriteRegW = 1; RegWriteW = 1; RtE = 1; #1;
      chk("fwd_ae_w", int'(ForwardAE), 1);
      chk("fwd_be_w", int'(ForwardBE), 1);
      RsE = 0; RtE = 0; WriteRegM = 0; RegWriteM = 1; WriteRegW = 0; #1;
      chk("fwd_ae_r0", int'(ForwardAE), 0);
      clear_in();
      RsD = 4; UsesRsD = 1; WriteRegM = 4; RegWriteM = 1; #1;
      chk("fwd_ad", int'(ForwardAD), 1);
      chk("fwd_ad_nostall", int'(StallD), 0);

      // load-use with source-use qualification
      clear_in();
      MemtoRegE = 1; RegWriteE = 1; RtE = 2; WriteRegE = 2; RsD = 2; RtD = 2; #1;
      chk("lw_unused", int'(StallD), 0);
      UsesRsD = 1; #1;
      chk("lw_stall", int'(StallD), 1);
      chk("lw_flush", int'(FlushE), 1);
      tick();
      clear_in(); #1;
      chk("lw_release", int'(StallD), 0);
      chk("lw_count", int'(StallCount), 1);
      ClrCount = 1; tick(); ClrCount = 0; #1;
      chk("clr_count", int'(StallCount), 0);

      // mult -> $5 followed by a reader of $5
      MDIssueE = 1; WriteRegE = 5; RsD = 5; UsesRsD = 1; #1;
      chk("md_c0_stall", int'(StallD), 1);
      chk("md_c0_busy", int'(MDBusy), 0);
      tick();
      MDIssueE = 0; WriteRegE = 0; #1;
      chk("md_c1_stall", int'(StallD), 1);
      chk("md_c1_busy", int'(MDBusy), 1);
      chk("md_c1_done", int'(MDDone), 0);
      chk("md_c1_reg", int'(MDWriteReg), 5);
      chk("lat1_done", int'(n_MDDone), 1);
      chk("lat1_release", int'(n_StallD), 0);
      tick(); #1;
      chk("md_c2_stall", int'(StallD), 1);
      chk("lat1_idle", int'(n_MDBusy), 0);
      tick(); #1;
      chk("md_c3_stall", int'(StallD), 1);
      chk("md_c3_done", int'(MDDone), 0);
      tick(); #1;
      chk("md_c4_done", int'(MDDone), 1);
      chk("md_c4_release", int'(StallD), 0);
      chk("md_count", int'(StallCount), 4);
      clear_in(); tick(); #1;
      chk("md_c5_idle", int'(MDBusy), 0);
      chk("md_c5_count", int'(StallCount), 4);

      // structural stall, then back-to-back issue in the MDDone cycle
      MDIssueE = 1; WriteRegE = 6; MDStartD = 1; #1;
      chk("st_issue_stall", int'(StallD), 1);
      tick();
      MDIssueE = 0; WriteRegE = 0; #1;
      chk("st_busy_stall", int'(StallD), 1);
      tick(); tick(); #1;
      chk("st_c3_stall", int'(StallD), 1);
      tick(); #1;
      chk("st_done_release", int'(StallD), 0);
      MDStartD = 0; MDIssueE = 1; WriteRegE = 7; #1;
      chk("b2b_done", int'(MDDone), 1);
      chk("b2b_oldreg", int'(MDWriteReg), 6);
      tick();
      MDIssueE = 0; WriteRegE = 0; #1;
      chk("b2b_busy", int'(MDBusy), 1);
      chk("b2b_notdone", int'(MDDone), 0);
      chk("b2b_newreg", int'(MDWriteReg), 7);
      RegWriteD = 1; WriteRegD = 7; #1;
      chk("waw_stall", int'(StallD), 1);
      RegWriteD = 0; #1;
      chk("waw_nowrite", int'(StallD), 0);
      tick();

      // reset abandons the operation with cnt=2
      reset = 1; RsD = 7; UsesRsD = 1; RsE = 1; WriteRegM = 1; RegWriteM = 1; #1;
      chk("rb_flush", int'(FlushE), 1);
      chk("rb_stall", int'(StallD), 0);
      chk("rb_done", int'(MDDone), 0);
      chk("rb_fwd", int'(ForwardAE), 0);
      tick();
      reset = 0; clear_in(); #1;
      chk("rb_idle", int'(MDBusy), 0);
      chk("rb_count", int'(StallCount), 0);
      chk("rb_mdreg", int'(MDWriteReg), 0);
      seen_done = 0;
      for (int i = 0; i < 5; i++) begin
         if (MDDone) seen_done = 1;
         tick();
      end
      chk("rb_no_done", int'(seen_done), 0);

      // branch hazards, both modes
      BranchD = 1; RsD = 3; UsesRsD = 1; RtD = 9; UsesRtD = 1; WriteRegM = 3; RegWriteM = 1; #1;
      chk("nf_br_stall", int'(n_StallD), 1);
      chk("nf_br_fwd", int'(n_ForwardAD), 0);
      chk("f_br_fwd", int'(ForwardAD), 1);
      chk("f_br_nostall", int'(StallD), 0);
      RegWriteM = 0; WriteRegM = 0; WriteRegW = 3; RegWriteW = 1; #1;
      chk("nf_br_w", int'(n_StallD), 0);
      RegWriteE = 1; WriteRegE = 9; #1;
      chk("f_br_estall", int'(StallD), 1);

      // 2-bit counter saturation and clear priority
      clear_in();
      ClrCount = 1; tick(); ClrCount = 0;
      RsD = 3; UsesRsD = 1; WriteRegM = 3; RegWriteM = 1;
      for (int i = 0; i < 5; i++) tick();
      chk("sat_count", int'(n_StallCount), 3);
      chk("sat_stall", int'(n_StallD), 1);
      ClrCount = 1; tick(); ClrCount = 0; #1;
      chk("clr_prio", int'(n_StallCount), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
